// File: rtl/sd_wr_pkg.sv
// Shared state encoding and default geometry for the SD write-side byte packer.
// No logic; constants only.
// No flow control; constants only.
package sd_wr_pkg;

    localparam int DEF_WORDS_PER_SECTOR = 256;
    localparam int DEF_SECTOR_LIMIT     = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } sd_state_e;

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_RUN  = RUN;
    localparam logic [1:0] ST_HOLD = HOLD;
    localparam logic [1:0] ST_DONE = DONE;

endpackage

// File: rtl/sd_byte_packer_if.sv
// Byte stream in and 16-bit FIFO write strobe out of the SD byte packer.
// Wires only, no latency.
// din_ready is the only backpressure; the FIFO side has no ready, full is sampled by the packer.
interface sd_byte_packer_if;
    import sd_wr_pkg::*;

    logic [7:0]  din;
    logic        din_valid;
    logic        din_ready;
    logic        fifo_wr_en;
    logic [15:0] fifo_wr_data;

    modport master (
        output din,
        output din_valid,
        input  din_ready,
        input  fifo_wr_en,
        input  fifo_wr_data
    );

    modport slave (
        input  din,
        input  din_valid,
        output din_ready,
        output fifo_wr_en,
        output fifo_wr_data
    );

endinterface

// File: rtl/sd_sector_counter.sv
// Word-in-sector and sector-in-session counting with sector_done pulse and limit detect.
// Counts and sector_done register on the edge after word_stb; limit_hit is combinational.
// No backpressure; every word_stb advances the count, written or dropped.
module sd_sector_counter
    import sd_wr_pkg::*;
#(
    parameter int WORDS_PER_SECTOR = DEF_WORDS_PER_SECTOR,
    parameter int SECTOR_LIMIT     = DEF_SECTOR_LIMIT
) (
    input  logic        wr_clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        word_stb,
    output logic        sector_done,
    output logic [15:0] sector_cnt,
    output logic        limit_hit
);

    localparam int              WCW         = (WORDS_PER_SECTOR > 1) ? $clog2(WORDS_PER_SECTOR) : 1;
    localparam logic [WCW-1:0]  LAST_WORD   = WCW'(WORDS_PER_SECTOR - 1);
    localparam logic [15:0]     LAST_SECTOR = 16'(SECTOR_LIMIT - 1);

    logic [WCW-1:0] word_cnt;
    logic           last_word;

    assign last_word = (word_cnt == LAST_WORD);
    // Fires in the cycle the final word of the session is strobed, so the FSM lands in DONE with the count.
    assign limit_hit = word_stb && last_word && (sector_cnt == LAST_SECTOR);

    always_ff @(posedge wr_clk or negedge rst_n) begin
        if (!rst_n) begin
            word_cnt    <= '0;
            sector_cnt  <= '0;
            sector_done <= 1'b0;
        end else begin
            sector_done <= 1'b0;
            if (clr) begin
                word_cnt   <= '0;
                sector_cnt <= '0;
            end else if (word_stb) begin
                if (last_word) begin
                    word_cnt    <= '0;
                    sector_cnt  <= sector_cnt + 16'd1;
                    sector_done <= 1'b1;
                end else begin
                    word_cnt <= word_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/sd_byte_packer.sv
// Packs byte pairs (first byte high) into 16-bit FIFO words per SD session; SD_TESTPAT_EN swaps input for a word-index pattern.
// Word appears on fifo_wr_en/fifo_wr_data one cycle after its second byte is accepted.
// din_ready drops on prog_full (HOLD); a write slot that meets full drops the word and sets sticky overflow.
module sd_byte_packer
    import sd_wr_pkg::*;
#(
    parameter int WORDS_PER_SECTOR = DEF_WORDS_PER_SECTOR,
    parameter int SECTOR_LIMIT     = DEF_SECTOR_LIMIT
) (
    input  logic                wr_clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                sd_init_done,
    input  logic                wr_rst_busy,
    input  logic                prog_full,
    input  logic                full,
    sd_byte_packer_if.slave     bus,
    output logic                sector_done,
    output logic [15:0]         sector_cnt,
    output logic                fifo_wr_finish,
    output logic                overflow
);

    logic [1:0]  rst_sync;
    logic        run_en;
    logic [1:0]  state;
    logic        link_ok;
    logic        start_ok;
    logic        abort;
    logic        flow_ok;
    logic        word_stb;
    logic [15:0] word_dat;
    logic        limit_hit;
    logic        wr_pend;
    logic [15:0] wr_data_q;

    // Reset assertion is immediate; release must pass two flops before the FSM may leave IDLE.
    always_ff @(posedge wr_clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end
    assign run_en = rst_sync[1];

    assign link_ok  = sd_init_done && !wr_rst_busy;
    assign start_ok = start && link_ok && run_en && ((state == ST_IDLE) || (state == ST_DONE));
    assign abort    = ((state == ST_RUN) || (state == ST_HOLD)) && !link_ok;
    assign flow_ok  = (state == ST_RUN) && !prog_full && link_ok;

`ifdef SD_TESTPAT_EN
    logic [15:0] tp_idx;
    logic        unused_din;

    assign unused_din    = ^{bus.din, bus.din_valid};
    assign bus.din_ready = 1'b0;
    assign word_stb      = flow_ok;
    assign word_dat      = tp_idx;

    always_ff @(posedge wr_clk or negedge rst_n) begin
        if (!rst_n) begin
            tp_idx <= '0;
        end else if (start_ok) begin
            tp_idx <= '0;
        end else if (word_stb) begin
            tp_idx <= tp_idx + 16'd1;
        end
    end
`else
    logic       byte_phase;
    logic [7:0] hi_byte;
    logic       take;

    assign bus.din_ready = flow_ok;
    assign take          = flow_ok && bus.din_valid;
    assign word_stb      = take && byte_phase;
    assign word_dat      = {hi_byte, bus.din};

    // A half-packed byte never survives an abort or a new session.
    always_ff @(posedge wr_clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_phase <= 1'b0;
            hi_byte    <= '0;
        end else if (start_ok || abort) begin
            byte_phase <= 1'b0;
        end else if (take) begin
            if (!byte_phase) begin
                hi_byte <= bus.din;
            end
            byte_phase <= ~byte_phase;
        end
    end
`endif

    always_ff @(posedge wr_clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_pend   <= 1'b0;
            wr_data_q <= '0;
            overflow  <= 1'b0;
        end else begin
            wr_pend <= word_stb;
            if (word_stb) begin
                wr_data_q <= word_dat;
            end
            if (start_ok) begin
                overflow <= 1'b0;
            end else if (wr_pend && full) begin
                overflow <= 1'b1;
            end
        end
    end

    // full is judged in the write slot itself, so the strobe is gated combinationally.
    assign bus.fifo_wr_en   = wr_pend && !full;
    assign bus.fifo_wr_data = wr_data_q;

    always_ff @(posedge wr_clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start_ok) state <= ST_RUN;
                end
                ST_RUN: begin
                    if (!link_ok)       state <= ST_IDLE;
                    else if (limit_hit) state <= ST_DONE;
                    else if (prog_full) state <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (!link_ok)        state <= ST_IDLE;
                    else if (!prog_full) state <= ST_RUN;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge wr_clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_wr_finish <= 1'b0;
        end else begin
            fifo_wr_finish <= (state == ST_DONE) && !start_ok;
        end
    end

    sd_sector_counter #(
        .WORDS_PER_SECTOR (WORDS_PER_SECTOR),
        .SECTOR_LIMIT     (SECTOR_LIMIT)
    ) u_cnt (
        .wr_clk      (wr_clk),
        .rst_n       (rst_n),
        .clr         (start_ok),
        .word_stb    (word_stb),
        .sector_done (sector_done),
        .sector_cnt  (sector_cnt),
        .limit_hit   (limit_hit)
    );

endmodule

// File: tb/tb_sd_byte_packer.sv
// Scoreboard bench for sd_byte_packer: words are queued with their due cycle as bytes are sent.
// Build with SD_TESTPAT_EN to exercise the test-pattern session instead of byte packing.
module tb_sd_byte_packer;
    import sd_wr_pkg::*;

    localparam int WPS  = 256;
    localparam int NSEC = 6;

    typedef struct {
        logic [15:0] dat;
        int          due;
    } exp_t;

    logic        wr_clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        sd_init_done;
    logic        wr_rst_busy;
    logic        prog_full;
    logic        full;
    logic        sector_done;
    logic [15:0] sector_cnt;
    logic        fifo_wr_finish;
    logic        overflow;

    sd_byte_packer_if bus ();

    sd_byte_packer dut (
        .wr_clk         (wr_clk),
        .rst_n          (rst_n),
        .start          (start),
        .sd_init_done   (sd_init_done),
        .wr_rst_busy    (wr_rst_busy),
        .prog_full      (prog_full),
        .full           (full),
        .bus            (bus),
        .sector_done    (sector_done),
        .sector_cnt     (sector_cnt),
        .fifo_wr_finish (fifo_wr_finish),
        .overflow       (overflow)
    );

    always #5 wr_clk = ~wr_clk;

    int   cyc = 0;
    always @(posedge wr_clk) cyc <= cyc + 1;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   sess_words = 0;
    int   sd_pulses = 0;
    bit   chk_sd = 0;
    bit   m_phase = 0;
    logic [7:0] m_hi = 8'h00;
    int   m_words = 0;

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge wr_clk);
            if (bus.fifo_wr_en === 1'b1) begin
                n_cmp++;
                if (sb_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_word: got %h at cycle %0d, required no write", bus.fifo_wr_data, cyc);
                end else begin
                    e = sb_q.pop_front();
                    if (bus.fifo_wr_data !== e.dat || cyc != e.due) begin
                        n_bad++;
                        $display("FAIL word: got %h at cycle %0d, required %h at cycle %0d",
                                 bus.fifo_wr_data, cyc, e.dat, e.due);
                    end
                end
                sess_words++;
            end
            if (sector_done === 1'b1) begin
                sd_pulses++;
                if (chk_sd) begin
                    n_cmp++;
                    if (!(bus.fifo_wr_en === 1'b1 && (sess_words % WPS) == 0)) begin
                        n_bad++;
                        $display("FAIL sector_done_align: wr_en %b words %0d, required wr_en 1 and words multiple of %0d",
                                 bus.fifo_wr_en, sess_words, WPS);
                    end
                end
            end
        end
    endtask

    task automatic do_start(output int s);
        @(negedge wr_clk);
        start = 1'b1;
        @(posedge wr_clk);
        #1;
        s = cyc;
        start = 1'b0;
        m_phase = 0;
        m_words = 0;
        sess_words = 0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit drop);
        int n = 0;
        exp_t e;
        @(negedge wr_clk);
        bus.din = b;
        bus.din_valid = 1'b1;
        #1;
        while (bus.din_ready !== 1'b1 && n < 200) begin
            @(negedge wr_clk);
            #1;
            n++;
        end
        if (bus.din_ready !== 1'b1) begin
            n_cmp++;
            n_bad++;
            $display("FAIL din_ready_timeout: got %b, required 1", bus.din_ready);
            bus.din_valid = 1'b0;
            return;
        end
        @(posedge wr_clk);
        #1;
        bus.din_valid = 1'b0;
        if (!m_phase) begin
            m_hi = b;
        end else begin
            m_words++;
            if (!drop) begin
                e.dat = {m_hi, b};
                e.due = cyc;
                sb_q.push_back(e);
            end
        end
        m_phase = ~m_phase;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 50) begin
            @(negedge wr_clk);
            n++;
        end
        @(negedge wr_clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; sd_init_done = 1'b1; wr_rst_busy = 1'b0;
        prog_full = 1'b0; full = 1'b0; bus.din = 8'h00; bus.din_valid = 1'b0;
        repeat (3) @(negedge wr_clk);
        #1;
        n_cmp++; if (bus.fifo_wr_en !== 1'b0) begin n_bad++; $display("FAIL reset_wr_en: got %b, required 0", bus.fifo_wr_en); end
        n_cmp++; if (bus.fifo_wr_data !== 16'h0) begin n_bad++; $display("FAIL reset_wr_data: got %h, required 0000", bus.fifo_wr_data); end
        n_cmp++; if (bus.din_ready !== 1'b0) begin n_bad++; $display("FAIL reset_din_ready: got %b, required 0", bus.din_ready); end
        n_cmp++; if (sector_done !== 1'b0 || sector_cnt !== 16'd0) begin n_bad++; $display("FAIL reset_sector: got %b/%0d, required 0/0", sector_done, sector_cnt); end
        n_cmp++; if (fifo_wr_finish !== 1'b0 || overflow !== 1'b0) begin n_bad++; $display("FAIL reset_flags: got %b/%b, required 0/0", fifo_wr_finish, overflow); end
        // Release and pulse start on the very first edge: the synchroniser must swallow it.
        @(negedge wr_clk);
        rst_n = 1'b1;
        start = 1'b1;
        @(posedge wr_clk);
        #1;
        start = 1'b0;
        @(negedge wr_clk);
        #1;
        n_cmp++; if (dut.state !== ST_IDLE || bus.din_ready !== 1'b0) begin n_bad++; $display("FAIL early_start: state %0d ready %b, required IDLE/0", dut.state, bus.din_ready); end
    endtask

    task automatic test_basic();
        int s;
        do_start(s);
        n_cmp++; if (bus.din_ready !== 1'b1) begin n_bad++; $display("FAIL start_ready: got %b, required 1", bus.din_ready); end
        send_byte(8'h12, 0);
        send_byte(8'h34, 0);
        send_byte(8'h56, 0);
        send_byte(8'h78, 0);
        wait_drain();
        n_cmp++; if (sb_q.size() != 0) begin n_bad++; $display("FAIL basic_drain: got %0d pending, required 0", sb_q.size()); end
    endtask

    task automatic test_prog_full();
        send_byte(8'hA1, 0);
        @(negedge wr_clk);
        bus.din = 8'hB2;
        bus.din_valid = 1'b1;
        prog_full = 1'b1;
        #1;
        n_cmp++; if (bus.din_ready !== 1'b0) begin n_bad++; $display("FAIL pf_ready: got %b, required 0", bus.din_ready); end
        @(posedge wr_clk);
        #1;
        n_cmp++; if (dut.state !== ST_HOLD) begin n_bad++; $display("FAIL pf_hold: state %0d, required %0d", dut.state, ST_HOLD); end
        repeat (3) @(negedge wr_clk);
        #1;
        n_cmp++; if (bus.din_ready !== 1'b0) begin n_bad++; $display("FAIL pf_ready_hold: got %b, required 0", bus.din_ready); end
        prog_full = 1'b0;
        bus.din_valid = 1'b0;
        send_byte(8'hB2, 0);
        send_byte(8'hC3, 0);
        send_byte(8'hD4, 0);
        wait_drain();
        n_cmp++; if (sb_q.size() != 0) begin n_bad++; $display("FAIL pf_drain: got %0d pending, required 0", sb_q.size()); end
    endtask

    task automatic test_overflow();
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        send_byte(8'h33, 0);
        send_byte(8'h44, 1);
        full = 1'b1;
        @(negedge wr_clk);
        n_cmp++; if (bus.fifo_wr_en !== 1'b0) begin n_bad++; $display("FAIL ovf_wr_en: got %b, required 0", bus.fifo_wr_en); end
        @(posedge wr_clk);
        #1;
        full = 1'b0;
        n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_flag: got %b, required 1", overflow); end
        n_cmp++; if (dut.u_cnt.word_cnt !== 8'(m_words % WPS)) begin n_bad++; $display("FAIL ovf_word_cnt: got %0d, required %0d", dut.u_cnt.word_cnt, m_words % WPS); end
        send_byte(8'h55, 0);
        send_byte(8'h66, 0);
        wait_drain();
        n_cmp++; if (sb_q.size() != 0 || overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_after: pending %0d overflow %b, required 0/1", sb_q.size(), overflow); end
    endtask

    task automatic test_abort();
        int s;
        send_byte(8'h99, 0);
        @(negedge wr_clk);
        sd_init_done = 1'b0;
        @(posedge wr_clk);
        #1;
        n_cmp++; if (dut.state !== ST_IDLE || bus.din_ready !== 1'b0) begin n_bad++; $display("FAIL abort_idle: state %0d ready %b, required IDLE/0", dut.state, bus.din_ready); end
        n_cmp++; if (sector_cnt !== 16'd0 || overflow !== 1'b1) begin n_bad++; $display("FAIL abort_hold: sector_cnt %0d overflow %b, required 0/1", sector_cnt, overflow); end
        @(negedge wr_clk);
        start = 1'b1;
        @(posedge wr_clk);
        #1;
        start = 1'b0;
        n_cmp++; if (dut.state !== ST_IDLE) begin n_bad++; $display("FAIL abort_start_ignored: state %0d, required IDLE", dut.state); end
        sd_init_done = 1'b1;
        do_start(s);
        n_cmp++; if (overflow !== 1'b0 || bus.din_ready !== 1'b1) begin n_bad++; $display("FAIL restart_clear: overflow %b ready %b, required 0/1", overflow, bus.din_ready); end
        send_byte(8'hAB, 0);
        send_byte(8'hCD, 0);
        wait_drain();
        n_cmp++; if (sb_q.size() != 0) begin n_bad++; $display("FAIL abort_drain: got %0d pending, required 0", sb_q.size()); end
    endtask

    task automatic test_full_session();
        int s;
        @(negedge wr_clk);
        wr_rst_busy = 1'b1;
        @(posedge wr_clk);
        #1;
        wr_rst_busy = 1'b0;
        n_cmp++; if (dut.state !== ST_IDLE) begin n_bad++; $display("FAIL busy_idle: state %0d, required IDLE", dut.state); end
        do_start(s);
        sd_pulses = 0;
        chk_sd = 1;
        for (int i = 0; i < WPS * NSEC * 2; i++) begin
            send_byte(8'(i ^ (i >> 3)), 0);
        end
        @(negedge wr_clk);
        n_cmp++; if (fifo_wr_finish !== 1'b0 || dut.state !== ST_DONE || bus.din_ready !== 1'b0) begin
            n_bad++; $display("FAIL done_entry: finish %b state %0d ready %b, required 0/DONE/0", fifo_wr_finish, dut.state, bus.din_ready); end
        @(negedge wr_clk);
        n_cmp++; if (fifo_wr_finish !== 1'b1) begin n_bad++; $display("FAIL finish: got %b, required 1", fifo_wr_finish); end
        n_cmp++; if (sector_cnt !== 16'(NSEC) || sd_pulses != NSEC) begin n_bad++; $display("FAIL session_counts: sector_cnt %0d pulses %0d, required %0d/%0d", sector_cnt, sd_pulses, NSEC, NSEC); end
        n_cmp++; if (sb_q.size() != 0 || sess_words != WPS * NSEC) begin n_bad++; $display("FAIL session_words: pending %0d words %0d, required 0/%0d", sb_q.size(), sess_words, WPS * NSEC); end
        chk_sd = 0;
        do_start(s);
        n_cmp++; if (sector_cnt !== 16'd0 || fifo_wr_finish !== 1'b0 || dut.u_cnt.word_cnt !== 8'd0 || bus.din_ready !== 1'b1) begin
            n_bad++; $display("FAIL done_restart: cnt %0d finish %b word %0d ready %b, required 0/0/0/1", sector_cnt, fifo_wr_finish, dut.u_cnt.word_cnt, bus.din_ready); end
    endtask

    task automatic test_async_reset();
        send_byte(8'h5A, 0);
        send_byte(8'hA5, 1);
        full = 1'b1;
        @(posedge wr_clk);
        #1;
        full = 1'b0;
        @(negedge wr_clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (overflow !== 1'b0 || bus.fifo_wr_data !== 16'h0 || bus.din_ready !== 1'b0 || dut.state !== ST_IDLE) begin
            n_bad++; $display("FAIL async_reset: overflow %b data %h ready %b state %0d, required 0/0000/0/IDLE", overflow, bus.fifo_wr_data, bus.din_ready, dut.state); end
    endtask

    task automatic test_testpat();
        int s;
        exp_t e;
        int n = 0;
        do_start(s);
        sd_pulses = 0;
        chk_sd = 1;
        for (int i = 0; i < WPS * NSEC; i++) begin
            e.dat = 16'(i);
            e.due = s + 1 + i;
            sb_q.push_back(e);
        end
        n_cmp++; if (bus.din_ready !== 1'b0) begin n_bad++; $display("FAIL tp_ready: got %b, required 0", bus.din_ready); end
        while (fifo_wr_finish !== 1'b1 && n < 2 * WPS * NSEC) begin
            @(negedge wr_clk);
            n++;
        end
        n_cmp++; if (fifo_wr_finish !== 1'b1 || dut.state !== ST_DONE) begin n_bad++; $display("FAIL tp_finish: finish %b state %0d, required 1/DONE", fifo_wr_finish, dut.state); end
        n_cmp++; if (sb_q.size() != 0 || sector_cnt !== 16'(NSEC) || sd_pulses != NSEC) begin
            n_bad++; $display("FAIL tp_counts: pending %0d cnt %0d pulses %0d, required 0/%0d/%0d", sb_q.size(), sector_cnt, sd_pulses, NSEC, NSEC); end
        chk_sd = 0;
    endtask

    initial begin
        bus.din = 8'h00;
        bus.din_valid = 1'b0;
        fork
            monitor();
        join_none
        test_reset();
`ifdef SD_TESTPAT_EN
        test_testpat();
`else
        test_basic();
        test_prog_full();
        test_overflow();
        test_abort();
        test_full_session();
        test_async_reset();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/sd_byte_packer.md
SD_BYTE_PACKER -- requirements
Module: sd_byte_packer

Interface
REQ-001 The block SHALL have parameter WORDS_PER_SECTOR, default 256, meaning 16-bit words per 512-byte SD sector.
REQ-002 The block SHALL have parameter SECTOR_LIMIT, default 6, meaning sectors per session (1536 words).
REQ-003 Port wr_clk  in  1  FIFO write-side clock, all logic on rising edge.
REQ-004 Port rst_n  in  1  reset, asynchronous, active-low.
REQ-005 Port start  in  1  single-cycle session start pulse.
REQ-006 Port sd_init_done  in  1  SD card initialised, level.
REQ-007 Port wr_rst_busy  in  1  FIFO write-side reset busy.
REQ-008 Port prog_full  in  1  FIFO programmable-full threshold reached.
REQ-009 Port full  in  1  FIFO full.
REQ-010 Port din  in  8  source byte.
REQ-011 Port din_valid  in  1  din is valid.
REQ-012 Port din_ready  out  1  byte accepted when din_valid && din_ready.
REQ-013 Port fifo_wr_en  out  1  FIFO write strobe, one cycle per word.
REQ-014 Port fifo_wr_data  out  16  packed word.
REQ-015 Port sector_done  out  1  one-cycle pulse per completed sector.
REQ-016 Port sector_cnt  out  16  completed sectors this session.
REQ-017 Port fifo_wr_finish  out  1  session complete, level.
REQ-018 Port overflow  out  1  sticky: word dropped because full was high.

Function
REQ-019 States SHALL be IDLE, RUN, HOLD, DONE.
REQ-020 IDLE->RUN on start && sd_init_done && !wr_rst_busy; start otherwise ignored.
REQ-021 RUN->HOLD when prog_full=1; HOLD->RUN when prog_full=0.
REQ-022 din_ready SHALL be 1 only in RUN with prog_full=0 (combinational).
REQ-023 First accepted byte of a pair SHALL go to fifo_wr_data[15:8], second to [7:0].
REQ-024 fifo_wr_en SHALL assert exactly one cycle after the second byte is accepted, data registered with it.
REQ-025 If full=1 in the cycle a word would be written, fifo_wr_en SHALL stay 0, the word is dropped, overflow sets, counters still advance.
REQ-026 A word counter (log2(WORDS_PER_SECTOR) bits) SHALL increment per word and wrap to 0 after WORDS_PER_SECTOR-1, pulsing sector_done and incrementing sector_cnt in the same cycle as that word's fifo_wr_en slot.
REQ-027 When sector_cnt reaches SECTOR_LIMIT, state SHALL go to DONE and fifo_wr_finish SHALL rise the next cycle.
REQ-028 DONE->RUN on a new start: clears sector_cnt, word counter, fifo_wr_finish; overflow cleared only by start.
REQ-029 sd_init_done=0 or wr_rst_busy=1 in RUN/HOLD SHALL force IDLE next cycle, discarding any half-packed byte; sector_cnt held.
REQ-030 Bytes presented while din_ready=0 SHALL NOT be consumed.

Reset
REQ-031 On rst_n=0: state IDLE, all outputs 0, byte-phase and counters 0, immediately and independent of wr_clk.
REQ-032 Reset release SHALL be synchronised internally with a 2-flop synchroniser before state leaves IDLE.

Configuration
REQ-033 With SD_TESTPAT_EN defined, din/din_valid SHALL be ignored and a word generated every RUN cycle carrying the session word index (0,1,2,...,1535) in fifo_wr_data; din_ready SHALL be 0.
REQ-034 Without SD_TESTPAT_EN, byte packing per REQ-023/024 applies.

Structure
REQ-035 Package sd_wr_pkg SHALL hold the state enum, default WORDS_PER_SECTOR and SECTOR_LIMIT constants.
REQ-036 Sub-module sd_sector_counter SHALL implement word/sector counting, sector_done and limit detect.

Verification
REQ-037 Reset, start, 4 bytes 0x12,0x34,0x56,0x78 -> fifo_wr_data 0x1234 then 0x5678, each one cycle after second byte.
REQ-038 Stream 1536*2 bytes -> 6 sector_done pulses every 256 words, sector_cnt=6, fifo_wr_finish=1, DONE.
REQ-039 prog_full=1 mid-pair -> din_ready=0, HOLD; release -> pairing resumes with no byte lost.
REQ-040 full=1 at write slot -> no fifo_wr_en, overflow=1, word count still +1.
REQ-041 sd_init_done drop after one byte -> IDLE, next start packs fresh pair from [15:8].
REQ-042 SD_TESTPAT_EN build, start -> words 0..1535 consecutive, fifo_wr_finish after 1536th.
